marian_apb_arbiter: RTL and testbench
=====================================

Name: marian_apb_arbiter

Overview:
- Shares one 32-bit APB3 completer (UART APB segment at UARTBase) between NrReq APB requesters, e.g. the AXI-to-APB bridge and the debug path.
- Presents an APB completer interface to each requester and an APB requester interface to the shared bus.
- Fair round-robin grant; one transfer in flight; sequences the IDLE/SETUP/ACCESS phases on the shared bus.

Parameters:
- NrReq, 2, number of requester ports (>=2).
- AddrWidth, 64, APB address width (matches axi_addr_t).
- DataWidth, 32, APB data width; strobe width = DataWidth/8.
- TimeoutCycles, 256, ACCESS-phase watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_psel_i  in  NrReq  requester select.
- req_penable_i  in  NrReq  requester enable (monitored only).
- req_pwrite_i  in  NrReq  requester write.
- req_paddr_i  in  NrReq x AddrWidth  requester address.
- req_pwdata_i  in  NrReq x DataWidth  requester write data.
- req_pstrb_i  in  NrReq x DataWidth/8  requester strobes.
- req_pready_o  out  NrReq  completion, one-hot.
- req_prdata_o  out  DataWidth  read data, shared, valid with req_pready_o.
- req_pslverr_o  out  NrReq  error, valid with req_pready_o.
- psel_o  out  1  shared-bus select.
- penable_o  out  1  shared-bus enable.
- pwrite_o  out  1  shared-bus write.
- paddr_o  out  AddrWidth  shared-bus address.
- pwdata_o  out  DataWidth  shared-bus write data.
- pstrb_o  out  DataWidth/8  shared-bus strobes.
- pready_i  in  1  shared-bus ready.
- prdata_i  in  DataWidth  shared-bus read data.
- pslverr_i  in  1  shared-bus error.
- grant_o  out  $clog2(NrReq)  index of the current or last granted requester (debug).

Behaviour:
- Reset: all outputs and registers are 0, state=IDLE, round-robin pointer=0. Reset asserted mid-transfer aborts it immediately; no completion is reported.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_psel_i is set, pick the first set bit at or after the pointer, wrapping modulo NrReq.
  - Register grant, pwrite, paddr, pwdata, pstrb from that port. Go to SETUP.
  - With no requests: psel_o=0, penable_o=0.
- SETUP: psel_o=1, penable_o=0, outputs driven from the captured registers. Unconditionally go to ACCESS next cycle.
- ACCESS: psel_o=1, penable_o=1. Hold until pready_i=1. In that cycle:
  - req_pready_o[grant]=1, combinational from pready_i.
  - req_prdata_o=prdata_i; req_pslverr_o[grant]=pslverr_i.
  - pointer <= grant+1, wrapping NrReq-1 to 0. Go to IDLE.
- Latency: request visible in cycle 0 -> SETUP in cycle 1 -> ACCESS in cycle 2. Earliest completion is cycle 2. There is a mandatory one-cycle IDLE between transfers.
- Non-granted ports: req_pready_o=0, req_pslverr_o=0.
- req_prdata_o: 0 whenever no completion is being reported.
- Shared-bus outputs stay stable through SETUP/ACCESS. Requester inputs are sampled only in IDLE.
- Requester drops psel before completion: this is a protocol violation. The shared transfer still completes, req_pready_o still pulses, and the response is discarded.
- Simultaneous requests are resolved by the pointer. Grant is fair: each pending requester waits at most NrReq-1 transfers.
- Requester holding psel after its own completion: treated as a new request in IDLE, subject to the pointer.

Optional Feature:
- Macro: MARIAN_APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each cycle while pready_i=0.
  - When the counter reaches TimeoutCycles-1, the arbiter forces completion: req_pready_o[grant]=1, req_pslverr_o[grant]=1, req_prdata_o=0.
  - It then drops psel_o/penable_o, advances the pointer and goes to IDLE. A late pready_i is ignored.
- Not defined: no counter; ACCESS waits indefinitely for pready_i.

Decomposition:
- marian_fpga_pkg receives:
  - apb_arb_state_e enum {IDLE, SETUP, ACCESS}.
  - ApbArbTimeoutCycles constant (256).
  - NrApbReq constant (2).
- Existing uart_apb_req_t/resp_t in marian_fpga_pkg are used at the top-level hookup.
- One sub-module: marian_rr_arbiter.
  - Combinational priority pick from a pointer over an NrReq request vector.
  - Outputs a valid flag and the grant index.
  - Keeps the pointer arithmetic out of the FSM.

Test Plan:
- Single write: port0 writes addr 0xC000_0004, data 0xA5, strb 0x1, pready_i tied 1. Expect psel_o in cycles 1-2, penable_o in cycle 2, req_pready_o=01 in cycle 2, paddr_o=0xC000_0004.
- Simultaneous requests: ports 0 and 1 both request after reset. Expect grant order 0,1,0,1 over 4 transfers, each with a one-cycle IDLE gap.
- Wait states: pready_i low for 5 ACCESS cycles during a read, then high with prdata_i=0xDEAD_BEEF and pslverr_i=1. Expect req_prdata_o=0xDEAD_BEEF and req_pslverr_o[grant]=1 for exactly one cycle; bus outputs stable throughout.
- Reset mid-ACCESS: rst_ni low for 1 cycle. Expect psel_o=0 immediately, no req_pready_o pulse, and next grant starts from port 0.
- Withdrawn request: port1 drops psel during ACCESS. Expect the shared transfer to finish and req_pready_o[1] to pulse; port0 is then served next.
- Timeout (MARIAN_APB_ARB_TIMEOUT_EN, TimeoutCycles=8): pready_i held 0. Expect forced completion on the 8th ACCESS cycle with pslverr=1 and rdata=0; without the macro, no completion after 1000 cycles.

Source files
------------

// File: rtl/marian_fpga_pkg.sv
// marian_fpga_pkg: shared types and constants for the Marian FPGA top.
// Holds the APB arbiter state encoding, its defaults and UART APB bundles.
package marian_fpga_pkg;

  localparam int unsigned NrApbReq            = 2;
  localparam int unsigned ApbArbTimeoutCycles = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [63:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } uart_apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } uart_apb_resp_t;

endpackage

// File: rtl/marian_rr_arbiter.sv
// marian_rr_arbiter: combinational round-robin pick.
// Returns the first request at or after ptr_i, wrapping to index 0.
module marian_rr_arbiter #(
  parameter  int unsigned NrReq = 2,
  localparam int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic [NrReq-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  logic            hi_vld;
  logic            lo_vld;
  logic [IdxW-1:0] hi_idx;
  logic [IdxW-1:0] lo_idx;

  // hi: first hit at/after the pointer; lo: first hit overall (the wrap case)
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned c = 0; c < NrReq; c++) begin
      if (req_i[c] && !hi_vld && (c >= 32'(ptr_i))) begin
        hi_vld = 1'b1;
        hi_idx = IdxW'(c);
      end
      if (req_i[c] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = IdxW'(c);
      end
    end
  end

  assign valid_o = hi_vld | lo_vld;
  assign idx_o   = hi_vld ? hi_idx : lo_idx;

endmodule

// File: rtl/marian_apb_arbiter.sv
// marian_apb_arbiter: round-robin sharing of one APB3 completer by NrReq requesters.
// Define MARIAN_APB_ARB_TIMEOUT_EN to add the ACCESS-phase watchdog.
module marian_apb_arbiter
  import marian_fpga_pkg::*;
#(
  parameter  int unsigned NrReq         = NrApbReq,
  parameter  int unsigned AddrWidth     = 64,
  parameter  int unsigned DataWidth     = 32,
  parameter  int unsigned TimeoutCycles = ApbArbTimeoutCycles,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned IdxW          = $clog2(NrReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrReq-1:0]                    req_psel_i,
  input  logic [NrReq-1:0]                    req_penable_i,
  input  logic [NrReq-1:0]                    req_pwrite_i,
  input  logic [NrReq-1:0][AddrWidth-1:0]     req_paddr_i,
  input  logic [NrReq-1:0][DataWidth-1:0]     req_pwdata_i,
  input  logic [NrReq-1:0][StrbWidth-1:0]     req_pstrb_i,
  output logic [NrReq-1:0]                    req_pready_o,
  output logic [DataWidth-1:0]                req_prdata_o,
  output logic [NrReq-1:0]                    req_pslverr_o,
  output logic                                psel_o,
  output logic                                penable_o,
  output logic                                pwrite_o,
  output logic [AddrWidth-1:0]                paddr_o,
  output logic [DataWidth-1:0]                pwdata_o,
  output logic [StrbWidth-1:0]                pstrb_o,
  input  logic                                pready_i,
  input  logic [DataWidth-1:0]                prdata_i,
  input  logic                                pslverr_i,
  output logic [IdxW-1:0]                     grant_o
);

  apb_arb_state_e state_q, state_d;

  logic [IdxW-1:0]      grant_q;
  logic [IdxW-1:0]      ptr_q;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_vld;
  logic                 pwrite_q;
  logic [AddrWidth-1:0] paddr_q;
  logic [DataWidth-1:0] pwdata_q;
  logic [StrbWidth-1:0] pstrb_q;
  logic                 done;
  logic                 forced;

  // penable from requesters carries no information the FSM needs
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

  marian_rr_arbiter #(
    .NrReq (NrReq)
  ) u_rr (
    .req_i   (req_psel_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

`ifdef MARIAN_APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW =
    (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !pready_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // a real pready in the limit cycle still wins over the forced error
  assign forced = (state_q == ACCESS) && !pready_i &&
                  (32'(cnt_q) == TimeoutCycles - 1);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TimeoutCycles);
  assign forced = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (pready_i || forced);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_vld) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q  <= '0;
      ptr_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else begin
      if (state_q == IDLE && pick_vld) begin
        grant_q  <= pick_idx;
        pwrite_q <= req_pwrite_i[pick_idx];
        paddr_q  <= req_paddr_i[pick_idx];
        pwdata_q <= req_pwdata_i[pick_idx];
        pstrb_q  <= req_pstrb_i[pick_idx];
      end
      if (done) begin
        ptr_q <= (32'(grant_q) == NrReq - 1) ? '0 : grant_q + IdxW'(1);
      end
    end
  end

  always_comb begin
    psel_o        = 1'b0;
    penable_o     = 1'b0;
    req_pready_o  = '0;
    req_pslverr_o = '0;
    req_prdata_o  = '0;
    unique case (state_q)
      SETUP: psel_o = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      default: ;
    endcase
    if (done) begin
      req_pready_o[grant_q]  = 1'b1;
      req_pslverr_o[grant_q] = forced | pslverr_i;
      req_prdata_o           = forced ? '0 : prdata_i;
    end
  end

  assign pwrite_o = pwrite_q;
  assign paddr_o  = paddr_q;
  assign pwdata_o = pwdata_q;
  assign pstrb_o  = pstrb_q;
  assign grant_o  = grant_q;

endmodule

// File: tb/tb_marian_apb_arbiter.sv
// tb_marian_apb_arbiter: directed and randomized bench for marian_apb_arbiter.
// Random traffic is checked against a transfer-level round-robin model.
module tb_marian_apb_arbiter;

  localparam int NR = 3;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  localparam int GW = $clog2(NR);

`ifdef MARIAN_APB_ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic [NR-1:0]         req_psel_i;
  logic [NR-1:0]         req_penable_i;
  logic [NR-1:0]         req_pwrite_i;
  logic [NR-1:0][AW-1:0] req_paddr_i;
  logic [NR-1:0][DW-1:0] req_pwdata_i;
  logic [NR-1:0][SW-1:0] req_pstrb_i;
  logic [NR-1:0]         req_pready_o;
  logic [DW-1:0]         req_prdata_o;
  logic [NR-1:0]         req_pslverr_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [AW-1:0]         paddr_o;
  logic [DW-1:0]         pwdata_o;
  logic [SW-1:0]         pstrb_o;
  logic                  pready_i;
  logic [DW-1:0]         prdata_i;
  logic                  pslverr_i;
  logic [GW-1:0]         grant_o;

  int checks = 0;
  int errors = 0;

  marian_apb_arbiter #(
    .NrReq         (NR),
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_psel_i    (req_psel_i),
    .req_penable_i (req_penable_i),
    .req_pwrite_i  (req_pwrite_i),
    .req_paddr_i   (req_paddr_i),
    .req_pwdata_i  (req_pwdata_i),
    .req_pstrb_i   (req_pstrb_i),
    .req_pready_o  (req_pready_o),
    .req_prdata_o  (req_prdata_o),
    .req_pslverr_o (req_pslverr_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .paddr_o       (paddr_o),
    .pwdata_o      (pwdata_o),
    .pstrb_o       (pstrb_o),
    .pready_i      (pready_i),
    .prdata_i      (prdata_i),
    .pslverr_i     (pslverr_i),
    .grant_o       (grant_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    req_psel_i    = '0;
    req_penable_i = '0;
    req_pwrite_i  = '0;
    req_paddr_i   = '0;
    req_pwdata_i  = '0;
    req_pstrb_i   = '0;
    pready_i      = 1'b0;
    prdata_i      = '0;
    pslverr_i     = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    idle_inputs();
    req_psel_i = '1;
    pready_i   = 1'b1;
    prdata_i   = 32'h1234_5678;
    pslverr_i  = 1'b1;
    #1;
    checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL reset_psel got %0b exp 0", psel_o); end
    checks++; if (penable_o !== 1'b0) begin errors++; $display("FAIL reset_penable got %0b exp 0", penable_o); end
    checks++; if (req_pready_o !== '0) begin errors++; $display("FAIL reset_pready got %b exp 0", req_pready_o); end
    checks++; if (req_prdata_o !== '0) begin errors++; $display("FAIL reset_prdata got %h exp 0", req_prdata_o); end
    checks++; if (req_pslverr_o !== '0) begin errors++; $display("FAIL reset_pslverr got %b exp 0", req_pslverr_o); end
    checks++; if (grant_o !== '0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_o); end
    checks++; if ({pwrite_o, paddr_o, pwdata_o, pstrb_o} !== '0) begin errors++; $display("FAIL reset_bus got %h %h %h exp 0", paddr_o, pwdata_o, pstrb_o); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL reset_hold_psel got %0b exp 0", psel_o); end
    rst_ni = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_write();
    reset_dut();
    @(negedge clk);
    req_psel_i[0]   = 1'b1;
    req_pwrite_i[0] = 1'b1;
    req_paddr_i[0]  = 64'hC000_0004;
    req_pwdata_i[0] = 32'h0000_00A5;
    req_pstrb_i[0]  = 4'h1;
    pready_i        = 1'b1;
    #1;
    checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL sw_c0_psel got %0b exp 0", psel_o); end
    @(negedge clk);
    req_penable_i[0] = 1'b1;
    #1;
    checks++; if ({psel_o, penable_o} !== 2'b10) begin errors++; $display("FAIL sw_c1_phase got %b exp 10", {psel_o, penable_o}); end
    checks++; if (paddr_o !== 64'hC000_0004) begin errors++; $display("FAIL sw_c1_paddr got %h exp c0000004", paddr_o); end
    checks++; if ({pwrite_o, pwdata_o, pstrb_o} !== {1'b1, 32'hA5, 4'h1}) begin errors++; $display("FAIL sw_c1_wfields got %b %h %h", pwrite_o, pwdata_o, pstrb_o); end
    checks++; if (req_pready_o !== '0) begin errors++; $display("FAIL sw_c1_pready got %b exp 000", req_pready_o); end
    @(negedge clk);
    #1;
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("FAIL sw_c2_phase got %b exp 11", {psel_o, penable_o}); end
    checks++; if (req_pready_o !== 3'b001) begin errors++; $display("FAIL sw_c2_pready got %b exp 001", req_pready_o); end
    checks++; if (req_pslverr_o !== '0) begin errors++; $display("FAIL sw_c2_pslverr got %b exp 000", req_pslverr_o); end
    checks++; if (paddr_o !== 64'hC000_0004) begin errors++; $display("FAIL sw_c2_paddr got %h exp c0000004", paddr_o); end
    @(negedge clk);
    req_psel_i[0]    = 1'b0;
    req_penable_i[0] = 1'b0;
    #1;
    checks++; if ({psel_o, req_pready_o} !== '0) begin errors++; $display("FAIL sw_c3_idle got %b %b exp 0", psel_o, req_pready_o); end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    int mptr;
    int ncomp;
    int last;
    int exp_g;
    logic [NR-1:0] exp_v;
    mptr  = 0;
    ncomp = 0;
    last  = 0;
    reset_dut();
    @(negedge clk);
    req_psel_i     = 3'b011;
    req_paddr_i[0] = 64'h100;
    req_paddr_i[1] = 64'h200;
    pready_i       = 1'b1;
    for (int cyc = 0; cyc < 40 && ncomp < 4; cyc++) begin
      #1;
      if (req_pready_o !== '0) begin
        exp_g = -1;
        for (int k = 0; k < NR; k++)
          if (exp_g < 0 && ((mptr + k) % NR) < 2) exp_g = (mptr + k) % NR;
        exp_v = '0;
        exp_v[GW'(exp_g)] = 1'b1;
        checks++; if (req_pready_o !== exp_v) begin errors++; $display("FAIL sim_order%0d got %b exp %b", ncomp, req_pready_o, exp_v); end
        checks++; if (paddr_o !== 64'(exp_g + 1) * 64'h100) begin errors++; $display("FAIL sim_paddr%0d got %h exp port %0d", ncomp, paddr_o, exp_g); end
        checks++; if (cyc != (ncomp == 0 ? 2 : last + 3)) begin errors++; $display("FAIL sim_gap%0d got cycle %0d exp %0d", ncomp, cyc, ncomp == 0 ? 2 : last + 3); end
        mptr = (exp_g + 1) % NR;
        last = cyc;
        ncomp++;
      end
      @(negedge clk);
    end
    checks++; if (ncomp != 4) begin errors++; $display("FAIL sim_count got %0d exp 4", ncomp); end
    idle_inputs();
  endtask

  task automatic test_wait_states();
    reset_dut();
    @(negedge clk);
    req_psel_i[1]   = 1'b1;
    req_pwrite_i[1] = 1'b0;
    req_paddr_i[1]  = 64'hC000_0010;
    req_pstrb_i[1]  = 4'h0;
    pready_i        = 1'b0;
    prdata_i        = 32'h5555_5555;
    pslverr_i       = 1'b1;
    @(negedge clk);
    req_paddr_i[1] = 64'hFFFF_0000;
    #1;
    checks++; if ({psel_o, penable_o} !== 2'b10) begin errors++; $display("FAIL ws_setup got %b exp 10", {psel_o, penable_o}); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);
      #1;
      checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b110) begin errors++; $display("FAIL ws_hold%0d_ctl got %b exp 110", k, {psel_o, penable_o, pwrite_o}); end
      checks++; if (paddr_o !== 64'hC000_0010) begin errors++; $display("FAIL ws_hold%0d_paddr got %h exp c0000010", k, paddr_o); end
      checks++; if ({req_pready_o, req_pslverr_o, req_prdata_o} !== '0) begin errors++; $display("FAIL ws_hold%0d_resp got %b %b %h exp 0", k, req_pready_o, req_pslverr_o, req_prdata_o); end
    end
    @(negedge clk);
    pready_i  = 1'b1;
    prdata_i  = 32'hDEAD_BEEF;
    pslverr_i = 1'b1;
    #1;
    checks++; if (req_pready_o !== 3'b010) begin errors++; $display("FAIL ws_done_pready got %b exp 010", req_pready_o); end
    checks++; if (req_prdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_done_prdata got %h exp deadbeef", req_prdata_o); end
    checks++; if (req_pslverr_o !== 3'b010) begin errors++; $display("FAIL ws_done_pslverr got %b exp 010", req_pslverr_o); end
    checks++; if (paddr_o !== 64'hC000_0010) begin errors++; $display("FAIL ws_done_paddr got %h exp c0000010", paddr_o); end
    @(negedge clk);
    req_psel_i[1] = 1'b0;
    #1;
    checks++; if ({psel_o, req_pready_o, req_pslverr_o, req_prdata_o} !== '0) begin errors++; $display("FAIL ws_after got %b %b %b %h exp 0", psel_o, req_pready_o, req_pslverr_o, req_prdata_o); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 1'b0;
    reset_dut();
    @(negedge clk);
    req_psel_i[0] = 1'b1;
    pready_i      = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_pready_o !== 3'b001) begin errors++; $display("FAIL rm_first got %b exp 001", req_pready_o); end
    @(negedge clk);
    req_psel_i = 3'b010;
    pready_i   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("FAIL rm_access got %b exp 11", {psel_o, penable_o}); end
    @(negedge clk);
    rst_ni   = 1'b0;
    pready_i = 1'b1;
    #1;
    checks++; if ({psel_o, penable_o} !== 2'b00) begin errors++; $display("FAIL rm_abort got %b exp 00", {psel_o, penable_o}); end
    checks++; if (req_pready_o !== '0) begin errors++; $display("FAIL rm_nopulse got %b exp 000", req_pready_o); end
    @(negedge clk);
    rst_ni     = 1'b1;
    req_psel_i = 3'b011;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      #1;
      if (req_pready_o !== '0) begin
        got = 1'b1;
        checks++; if (req_pready_o !== 3'b001) begin errors++; $display("FAIL rm_regrant got %b exp 001", req_pready_o); end
        checks++; if (cyc != 2) begin errors++; $display("FAIL rm_latency got %0d exp 2", cyc); end
      end
      @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL rm_timeout got none exp completion"); end
    idle_inputs();
  endtask

  task automatic test_withdrawn();
    bit got;
    got = 1'b0;
    reset_dut();
    @(negedge clk);
    req_psel_i[1]   = 1'b1;
    req_pwrite_i[1] = 1'b1;
    req_paddr_i[1]  = 64'hC000_0008;
    pready_i        = 1'b0;
    repeat (2) @(negedge clk);
    req_psel_i = 3'b001;
    #1;
    checks++; if ({psel_o, penable_o, paddr_o} !== {2'b11, 64'hC000_0008}) begin errors++; $display("FAIL wd_access got %b %h", {psel_o, penable_o}, paddr_o); end
    @(negedge clk);
    #1;
    checks++; if ({psel_o, req_pready_o} !== 4'b1000) begin errors++; $display("FAIL wd_wait got %b %b exp 1 000", psel_o, req_pready_o); end
    @(negedge clk);
    pready_i = 1'b1;
    #1;
    checks++; if (req_pready_o !== 3'b010) begin errors++; $display("FAIL wd_pulse got %b exp 010", req_pready_o); end
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge clk);
      #1;
      if (req_pready_o !== '0) begin
        got = 1'b1;
        checks++; if (req_pready_o !== 3'b001) begin errors++; $display("FAIL wd_next got %b exp 001", req_pready_o); end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL wd_timeout got none exp completion"); end
    idle_inputs();
  endtask

  task automatic test_timeout();
`ifndef MARIAN_APB_ARB_TIMEOUT_EN
    int seen;
    seen = 0;
`endif
    reset_dut();
    @(negedge clk);
    req_psel_i[0] = 1'b1;
    pready_i      = 1'b0;
    prdata_i      = 32'hCAFE_F00D;
    @(negedge clk);
`ifdef MARIAN_APB_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      #1;
      if (k < TO) begin
        checks++; if (req_pready_o !== '0) begin errors++; $display("FAIL to_early%0d got %b exp 000", k, req_pready_o); end
      end else begin
        checks++; if (req_pready_o !== 3'b001) begin errors++; $display("FAIL to_force_pready got %b exp 001", req_pready_o); end
        checks++; if (req_pslverr_o !== 3'b001) begin errors++; $display("FAIL to_force_pslverr got %b exp 001", req_pslverr_o); end
        checks++; if (req_prdata_o !== '0) begin errors++; $display("FAIL to_force_prdata got %h exp 0", req_prdata_o); end
      end
    end
    @(negedge clk);
    req_psel_i = '0;
    pready_i   = 1'b1;
    #1;
    checks++; if ({psel_o, req_pready_o} !== '0) begin errors++; $display("FAIL to_late got %b %b exp 0", psel_o, req_pready_o); end
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1;
      if (req_pready_o !== '0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL to_nocompl got %0d pulses exp 0", seen); end
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("FAIL to_stuck got %b exp 11", {psel_o, penable_o}); end
`endif
    idle_inputs();
  endtask

  task automatic test_random_traffic();
    int mptr;
    int m_grant;
    int m_age;
    int m_wait;
    bit m_idle;
    bit fin;
    bit frc;
    bit [NR-1:0] active;
    int waits[NR];
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_err;
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [SW-1:0] e_strb;
    logic          e_write;
    mptr = 0; m_grant = 0; m_age = 0; m_wait = 0; m_idle = 1'b1;
    active = '0;
    e_addr = '0; e_wdata = '0; e_strb = '0; e_write = 1'b0;
    for (int i = 0; i < NR; i++) waits[i] = 0;
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!active[i]) begin
          if ($urandom_range(0, 99) < 40) begin
            active[i]       = 1'b1;
            req_psel_i[i]   = 1'b1;
            req_pwrite_i[i] = 1'($urandom);
            req_paddr_i[i]  = {$urandom, $urandom};
            req_pwdata_i[i] = $urandom;
            req_pstrb_i[i]  = SW'($urandom);
          end else begin
            req_psel_i[i] = 1'b0;
          end
        end
      end
      pready_i  = 1'($urandom);
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);
      #1;
      fin = !m_idle && m_age >= 2 && pready_i;
      frc = TmoEn && !m_idle && m_age >= 2 && !pready_i && m_wait == TO - 1;
      exp_rdy = '0;
      exp_err = '0;
      exp_rdata = fin ? prdata_i : '0;
      if (fin || frc) begin
        exp_rdy[GW'(m_grant)] = 1'b1;
        exp_err[GW'(m_grant)] = frc | pslverr_i;
      end
      checks++; if ({psel_o, penable_o} !== {!m_idle, !m_idle && m_age >= 2}) begin errors++; $display("FAIL rnd_phase c%0d got %b exp %b", c, {psel_o, penable_o}, {!m_idle, !m_idle && m_age >= 2}); end
      checks++; if (req_pready_o !== exp_rdy) begin errors++; $display("FAIL rnd_pready c%0d got %b exp %b", c, req_pready_o, exp_rdy); end
      checks++; if (req_pslverr_o !== exp_err) begin errors++; $display("FAIL rnd_pslverr c%0d got %b exp %b", c, req_pslverr_o, exp_err); end
      checks++; if (req_prdata_o !== exp_rdata) begin errors++; $display("FAIL rnd_prdata c%0d got %h exp %h", c, req_prdata_o, exp_rdata); end
      checks++; if (grant_o !== GW'(m_grant)) begin errors++; $display("FAIL rnd_grant c%0d got %0d exp %0d", c, grant_o, m_grant); end
      if (!m_idle) begin
        checks++; if ({pwrite_o, paddr_o, pwdata_o, pstrb_o} !== {e_write, e_addr, e_wdata, e_strb}) begin errors++; $display("FAIL rnd_bus c%0d got %b %h %h %h exp %b %h %h %h", c, pwrite_o, paddr_o, pwdata_o, pstrb_o, e_write, e_addr, e_wdata, e_strb); end
      end
      if (req_pready_o !== '0) begin
        for (int i = 0; i < NR; i++) begin
          if (req_pready_o[i]) begin
            checks++; if (waits[i] > NR - 1) begin errors++; $display("FAIL rnd_fair c%0d port %0d waited %0d exp <= %0d", c, i, waits[i], NR - 1); end
            waits[i] = 0;
          end else if (active[i]) begin
            waits[i]++;
          end
        end
      end
      if (m_idle) begin
        if (req_psel_i != '0) begin
          m_grant = -1;
          for (int k = 0; k < NR; k++)
            if (m_grant < 0 && req_psel_i[(mptr + k) % NR]) m_grant = (mptr + k) % NR;
          e_write = req_pwrite_i[GW'(m_grant)];
          e_addr  = req_paddr_i[GW'(m_grant)];
          e_wdata = req_pwdata_i[GW'(m_grant)];
          e_strb  = req_pstrb_i[GW'(m_grant)];
          m_idle  = 1'b0;
          m_age   = 1;
          m_wait  = 0;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (fin || frc) begin
        active[GW'(m_grant)] = 1'b0;
        mptr   = (m_grant + 1) % NR;
        m_idle = 1'b1;
      end else begin
        m_wait++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_wait_states();
    test_reset_mid();
    test_withdrawn();
    test_timeout();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish before 2ms");
    $fatal(1);
  end

endmodule
